// File: rtl/bram_lsu_bridge.sv
// Byte-addressed load/store bridge onto a byte-masked, 1-cycle registered-read single-port BRAM.
// Latency: store/error response 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
// Optional feature macro: BRAM_BRIDGE_ERRCNT_EN adds the saturating err_cnt output.
module bram_lsu_bridge #(
  parameter int LENS  = 10,
  parameter int CNT_W = 16
) (
  input  logic            clka,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_uns,
  input  logic [LENS+1:0] req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [3:0]      ram_we,
  output logic [LENS-1:0] ram_addr,
  output logic [31:0]     ram_din,
  input  logic [31:0]     ram_dout
`ifdef BRAM_BRIDGE_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  // Load shaping info captured at accept, consumed when RAM data arrives in RD.
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } ld_meta_t;

  state_t          state_q, state_d;
  ld_meta_t        meta_q;
  logic [LENS-1:0] addr_q;
  logic [1:0]      off;
  logic            accept;
  logic            req_err;
  logic [3:0]      st_mask;
  logic [31:0]     ld_shift;
  logic [31:0]     ld_data;

  // Counter width must be at least one bit; this block only exists on a bad setting.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

  assign off       = req_addr[1:0];
  assign req_ready = (state_q == IDLE);
  // Reset gates accept so RAM writes stop the instant rst is raised.
  assign accept    = req_valid & req_ready & ~rst;

  // Misalignment / illegal size decode on the live request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd1:    req_err = off[0];
      2'd2:    req_err = (off != 2'd0);
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Store lane mask and lane-replicated write data.
  always_comb begin
    st_mask = 4'b0000;
    ram_din = req_wdata;
    case (req_size)
      2'd0: begin
        st_mask = 4'b0001 << off;
        ram_din = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_mask = 4'b0011 << off;
        ram_din = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        st_mask = 4'b1111;
        ram_din = req_wdata;
      end
      default: begin
        st_mask = 4'b0000;
        ram_din = req_wdata;
      end
    endcase
  end

  assign ram_we   = (accept && req_we && !req_err) ? st_mask : 4'b0000;
  assign ram_addr = accept ? req_addr[LENS+1:2] : addr_q;

  // Align RAM read data to the requested byte and extend to 32 bits.
  always_comb begin
    ld_shift = ram_dout >> {meta_q.off, 3'b000};
    ld_data  = ld_shift;
    case (meta_q.size)
      2'd0:    ld_data = meta_q.uns ? {24'd0, ld_shift[7:0]}
                                    : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_data = meta_q.uns ? {16'd0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: legal loads visit RD, everything else goes straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (!req_we && !req_err) ? RD : RESP;
      RD:   state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers, held RAM address and load metadata.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      addr_q    <= '0;
      meta_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          addr_q <= req_addr[LENS+1:2];
          meta_q <= '{off: off, size: req_size, uns: req_uns};
          if (req_we || req_err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_err;
            rsp_rdata <= 32'd0;
          end
        end
        RD: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld_data;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

`ifdef BRAM_BRIDGE_ERRCNT_EN
  // Saturating count of accepted requests that errored.
  always_ff @(posedge clka or posedge rst) begin
    if (rst)                              err_cnt <= '0;
    else if (accept && req_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_bram_lsu_bridge.sv
// Directed bench for bram_lsu_bridge with a byte-masked registered-read RAM model.
// Expected responses are queued at accept and popped when the bridge responds.
// Covers stores, signed/unsigned loads, errors, backpressure and mid-load reset.
module tb_bram_lsu_bridge;

  localparam int LENS  = 10;
  localparam int CNT_W = 16;

  logic            clka = 1'b0;
  logic            rst  = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [1:0]      req_size = 2'd0;
  logic            req_uns = 1'b0;
  logic [LENS+1:0] req_addr = '0;
  logic [31:0]     req_wdata = 32'd0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [3:0]      ram_we;
  logic [LENS-1:0] ram_addr;
  logic [31:0]     ram_din;
  logic [31:0]     ram_dout = 32'd0;
`ifdef BRAM_BRIDGE_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  bram_lsu_bridge #(.LENS(LENS), .CNT_W(CNT_W)) dut (
    .clka(clka), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef BRAM_BRIDGE_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clka = ~clka;

  // RAM model: per-byte write enables, registered read.
  logic [31:0] mem [0:(1<<LENS)-1];
  initial for (int i = 0; i < (1 << LENS); i++) mem[i] = 32'd0;
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request, check the RAM-side drive, and queue its expected response.
  task automatic send(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [LENS+1:0] addr, input logic [31:0] wd,
                      input logic [3:0] exp_we, input logic [31:0] exp_din,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    @(negedge clka);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".ram_we"}, 32'(ram_we), 32'(exp_we));
    chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(addr >> 2));
    if (exp_we != 4'd0) chk({tag, ".ram_din"}, ram_din, exp_din);
    @(posedge clka);
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'($urandom_range(0, 3));
    req_addr = (LENS+2)'($urandom); req_wdata = $urandom;
  endtask

  // Wait for the response, optionally stall it, then complete the handshake.
  task automatic get_rsp(input string tag, input int hold);
    exp_t e;
    int   lat = 0;
    bit   seen = 1'b0;
    while (lat < 10) begin
      @(negedge clka);
      lat++;
      if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    chk({tag, ".rsp_seen"}, 32'(seen), 32'd1);
    if (!seen || sb.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    chk({tag, ".rdata"}, rsp_rdata, e.rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      // A competing store while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
      req_addr = 12'h010; req_wdata = 32'hFFFF_FFFF;
      @(negedge clka);
      #1;
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, e.rdata);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_ram_we"}, 32'(ram_we), 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clka);
    #1;
    rsp_ready = 1'b0;
    @(negedge clka);
    chk({tag, ".after_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".after_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst.ram_we", 32'(ram_we), 32'd0);
`ifdef BRAM_BRIDGE_ERRCNT_EN
    chk("rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clka);
    rst = 1'b0;
    @(negedge clka);
    chk("idle.req_ready", 32'(req_ready), 32'd1);

    // Stores and aligned/extended loads.
    send("st_w", 1, 2'd2, 0, 12'h010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 32'd0, 0, 1);
    get_rsp("st_w", 0);
    send("ld_b_s", 0, 2'd0, 0, 12'h011, 32'd0, 4'h0, 32'd0, 32'hFFFF_FFBE, 0, 2);
    get_rsp("ld_b_s", 0);
    send("ld_h_u", 0, 2'd1, 1, 12'h012, 32'd0, 4'h0, 32'd0, 32'h0000_DEAD, 0, 2);
    get_rsp("ld_h_u", 0);
    send("ld_h_s", 0, 2'd1, 0, 12'h012, 32'd0, 4'h0, 32'd0, 32'hFFFF_DEAD, 0, 2);
    get_rsp("ld_h_s", 0);
    send("st_b", 1, 2'd0, 0, 12'h013, 32'h0000_005A, 4'b1000, 32'h5A5A_5A5A, 32'd0, 0, 1);
    get_rsp("st_b", 0);

    // Backpressure for 5 cycles with an ignored store presented meanwhile.
    send("ld_w_bp", 0, 2'd2, 0, 12'h010, 32'd0, 4'h0, 32'd0, 32'h5AAD_BEEF, 0, 2);
    get_rsp("ld_w_bp", 5);
    send("ld_w_again", 0, 2'd2, 1, 12'h010, 32'd0, 4'h0, 32'd0, 32'h5AAD_BEEF, 0, 2);
    get_rsp("ld_w_again", 0);

    // Upper-half store and reads around it.
    send("st_h", 1, 2'd1, 0, 12'h016, 32'hAAAA_1234, 4'b1100, 32'h1234_1234, 32'd0, 0, 1);
    get_rsp("st_h", 0);
    send("ld_w14", 0, 2'd2, 0, 12'h014, 32'd0, 4'h0, 32'd0, 32'h1234_0000, 0, 2);
    get_rsp("ld_w14", 0);
    send("ld_b_u17", 0, 2'd0, 1, 12'h017, 32'd0, 4'h0, 32'd0, 32'h0000_0012, 0, 2);
    get_rsp("ld_b_u17", 0);

    // Error cases: misaligned half, misaligned word store, illegal size.
    send("err_ld_h", 0, 2'd1, 0, 12'h021, 32'd0, 4'h0, 32'd0, 32'd0, 1, 1);
    get_rsp("err_ld_h", 0);
    send("err_st_w", 1, 2'd2, 0, 12'h022, 32'hCAFE_F00D, 4'h0, 32'd0, 32'd0, 1, 1);
    get_rsp("err_st_w", 0);
    send("err_sz3", 1, 2'd3, 0, 12'h024, 32'h1111_1111, 4'h0, 32'd0, 32'd0, 1, 1);
    get_rsp("err_sz3", 0);
`ifdef BRAM_BRIDGE_ERRCNT_EN
    chk("err_cnt.after_errs", 32'(err_cnt), 32'd3);
`endif
    send("ld_w20", 0, 2'd2, 0, 12'h020, 32'd0, 4'h0, 32'd0, 32'd0, 0, 2);
    get_rsp("ld_w20", 0);

    // Reset during the RD cycle of a load: no response may ever appear.
    send("ld_rst", 0, 2'd2, 0, 12'h010, 32'd0, 4'h0, 32'd0, 32'h5AAD_BEEF, 0, 2);
    @(negedge clka);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h030; req_wdata = 32'h7777_7777;
    #1;
    chk("rst_mid.ram_we", 32'(ram_we), 32'd0);
    chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clka);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    void'(sb.pop_front());
    begin
      int vld_seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clka);
        if (rsp_valid !== 1'b0) vld_seen++;
      end
      chk("rst_mid.no_rsp", 32'(vld_seen), 32'd0);
    end
    chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
`ifdef BRAM_BRIDGE_ERRCNT_EN
    chk("rst_mid.err_cnt", 32'(err_cnt), 32'd0);
`endif
    // Write during reset must not have landed.
    send("ld_w30", 0, 2'd2, 0, 12'h030, 32'd0, 4'h0, 32'd0, 32'd0, 0, 2);
    get_rsp("ld_w30", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
